// File: rtl/fhe_cmd_issuer_pkg.sv
// Shared types for the FHE command issuer: command/status ports, issuer FSM
// states and the blocking-command classifier.
package fhe_cmd_issuer_pkg;

    localparam int COMMAND_WIDTH     = 8;
    localparam int DATA_WIDTH        = 64;
    localparam int STACK_BUFFER_SIZE = 32;
    localparam int ISSUER_TIMEOUT    = 1048576;

    localparam logic [DATA_WIDTH-1:0] STATE_IDLE = '0;

    localparam logic [COMMAND_WIDTH-1:0] CMD_SET_MODULE1 = 8'd20;
    localparam logic [COMMAND_WIDTH-1:0] CMD_SET_RAM1    = 8'd23;
    localparam logic [COMMAND_WIDTH-1:0] CMD_NTT_RUN1    = 8'd41;
    localparam logic [COMMAND_WIDTH-1:0] COMMAND_RESET   = 8'd111;

    typedef enum logic [2:0] {IDLE, ISSUE, ACKW, DONEW, GAP} IssuerState;

    // One queued host command
    typedef struct packed {
        logic [COMMAND_WIDTH-1:0] command;
        logic [DATA_WIDTH-1:0]    data0;
        logic [DATA_WIDTH-1:0]    data1;
    } cmd_entry_t;

    // Command as seen by the ALU decoder; fields hold, only valid pulses
    typedef struct packed {
        logic                     valid;
        logic [COMMAND_WIDTH-1:0] command;
        logic [DATA_WIDTH-1:0]    data0;
        logic [DATA_WIDTH-1:0]    data1;
    } CommandDataPort;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] state0;
    } StatePort;

    // Long-running ALU ops (NTT/INTT/MULTI runs, vector ops, perm/auto) that
    // must finish before the next command goes out.
    function automatic logic is_blocking_cmd(input logic [COMMAND_WIDTH-1:0] cmd);
        return (cmd >= 8'd41) && (cmd <= 8'd92);
    endfunction

endpackage

// File: rtl/fhe_cmd_issuer_if.sv
// Host push bus plus the ALU-facing command/status ports of the issuer.
interface fhe_cmd_issuer_if
    import fhe_cmd_issuer_pkg::*;
();
    logic                     in_valid;
    logic                     in_ready;
    logic [COMMAND_WIDTH-1:0] in_command;
    logic [DATA_WIDTH-1:0]    in_data0;
    logic [DATA_WIDTH-1:0]    in_data1;
    logic                     flush;
    CommandDataPort           cmd_out;
    StatePort                 state_in;

    modport master (
        output in_valid, in_command, in_data0, in_data1, flush, state_in,
        input  in_ready, cmd_out
    );

    modport slave (
        input  in_valid, in_command, in_data0, in_data1, flush, state_in,
        output in_ready, cmd_out
    );
endinterface

// File: rtl/fhe_cmd_issuer_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally and the
// consumer registers it. flush empties the queue and beats a same-cycle push.
module fhe_cmd_fifo
    import fhe_cmd_issuer_pkg::*;
#(
    parameter int DEPTH = STACK_BUFFER_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  cmd_entry_t                 wdata,
    output cmd_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    cmd_entry_t     mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    // Storage array, no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fhe_cmd_issuer.sv
// Host-side CommandDataPort transmitter: queues host commands and issues them
// one at a time as single-cycle valid pulses, pacing blocking ALU commands on
// state0 returning to idle.
module fhe_cmd_issuer
    import fhe_cmd_issuer_pkg::*;
#(
    parameter int DEPTH      = STACK_BUFFER_SIZE,
    parameter int ACK_LAT    = 2,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = ISSUER_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    fhe_cmd_issuer_if.slave            bus,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       timeout_err
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (ACK_LAT > 1)    ? $clog2(ACK_LAT)    : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

    IssuerState     state;
    CommandDataPort cmd_q;
    cmd_entry_t     head;
    logic [CW-1:0]  count;
    logic           empty, full;
    logic           pop, gap_done, state_idle;
    logic [AW-1:0]  ack_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [TW-1:0]  to_cnt;

    fhe_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .flush (bus.flush),
        .wdata ({bus.in_command, bus.in_data0, bus.in_data1}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign gap_done   = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign state_idle = (bus.state_in.state0 == STATE_IDLE);

    // An issue slot opens in IDLE, or on the last GAP cycle so that
    // back-to-back issues are spaced exactly 1+GAP_CYCLES apart.
    assign pop = !empty && !bus.flush &&
                 ((state == IDLE) || ((state == GAP) && gap_done));

    assign bus.in_ready = !full;
    assign bus.cmd_out  = cmd_q;
    assign busy         = (state != IDLE) || !empty;
    assign fifo_count   = count;

    // Issue FSM with its ack-latency, gap and idle-wait timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            ack_cnt     <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            cmd_q.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_q <= {1'b1, head};
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack_cnt <= '0;
                    gap_cnt <= '0;
                    to_cnt  <= '0;
                    if (is_blocking_cmd(cmd_q.command))
                        state <= (ACK_LAT == 0) ? DONEW : ACKW;
                    else
                        state <= GAP;
                end
                ACKW: begin
                    if (ack_cnt == AW'(ACK_LAT - 1)) begin
                        to_cnt <= '0;
                        state  <= DONEW;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                DONEW: begin
                    // Idle wins over a timeout expiring on the same cycle
                    if (state_idle) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (pop) begin
                            cmd_q <= {1'b1, head};
                            state <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
